// File: rtl/vga_sync_decoder.sv
// Recovers hcount/vcount from an incoming VGA timing stream, locks onto it,
// and flags any sync/blank disagreement once locked.
module vga_sync_decoder #(
  parameter int HOR_TOTAL    = 1344,
  parameter int VER_TOTAL    = 806,
  parameter int HSYNC_START  = 1048,
  parameter int VSYNC_START  = 771,
  parameter int HBLANK_START = 1024,
  parameter int VBLANK_START = 768,
  parameter int LOCK_LINES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        locked,
  output logic        frame_start,
  output logic        timing_err,
  output logic [7:0]  err_cnt,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_SEARCH  = 3'd0,
    ST_H_TRACK = 3'd1,
    ST_V_WAIT  = 3'd2,
    ST_V_TRACK = 3'd3,
    ST_LOCKED  = 3'd4
  } state_e;

  localparam logic [10:0] H_LAST  = 11'(HOR_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(VER_TOTAL - 1);
  localparam logic [10:0] H_SYNC  = 11'(HSYNC_START);
  localparam logic [10:0] V_SYNC  = 11'(VSYNC_START);
  localparam logic [10:0] H_BLANK = 11'(HBLANK_START);
  localparam logic [10:0] V_BLANK = 11'(VBLANK_START);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_LINES);

  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic        hsync_prev_q, vsync_prev_q;
  logic [10:0] hcount_q, vcount_q;
  state_e      state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic        frame_start_q, frame_start_d;
  logic        timing_err_q, timing_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        hs_edge, vs_edge, h_wrap;
  logic [10:0] free_h, free_v, n_h, n_v;
  logic        h_bad, v_bad, blank_bad;

  assign hs_edge = hsync_q & ~hsync_prev_q;
  assign vs_edge = vsync_q & ~vsync_prev_q;

  // Free-running positions ignore the sync edges; edges are judged against them.
  assign free_h = (hcount_q == H_LAST) ? 11'd0 : hcount_q + 11'd1;
  assign h_wrap = (hcount_q == H_LAST) & ~hs_edge;

  always_comb begin
    free_v = vcount_q;
    if (h_wrap) free_v = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
  end

  assign n_h = hs_edge ? H_SYNC : free_h;
  assign n_v = vs_edge ? V_SYNC : free_v;

  assign h_bad     = hs_edge & (free_h != H_SYNC);
  assign v_bad     = vs_edge & (free_v != V_SYNC);
  assign blank_bad = (hblnk_q != (n_h >= H_BLANK)) | (vblnk_q != (n_v >= V_BLANK));

  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    timing_err_d = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        if (hs_edge) begin
          state_d = ST_H_TRACK;
          good_d  = 3'd0;
        end
      end
      ST_H_TRACK: begin
        if (hs_edge) begin
          if (h_bad) begin
            good_d = 3'd0;
          end else begin
            good_d = good_q + 3'd1;
            if (good_q + 3'd1 == LOCK_N) state_d = ST_V_WAIT;
          end
        end
      end
      ST_V_WAIT: begin
        if (h_bad) begin
          state_d = ST_H_TRACK;
          good_d  = 3'd0;
        end else if (vs_edge) begin
          state_d = ST_V_TRACK;
        end
      end
      ST_V_TRACK: begin
        if (h_bad) begin
          state_d = ST_H_TRACK;
          good_d  = 3'd0;
        end else if (vs_edge) begin
          state_d = v_bad ? ST_V_WAIT : ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // Several checks failing together still count as one error.
        if (h_bad | v_bad | blank_bad) begin
          timing_err_d = 1'b1;
          state_d      = ST_H_TRACK;
          good_d       = 3'd0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        good_d  = 3'd0;
      end
    endcase
  end

  assign err_cnt_d     = (timing_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  assign frame_start_d = (state_q == ST_LOCKED) && (n_h == 11'd0) && (n_v == 11'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_prev_q  <= 1'b0;
      vsync_prev_q  <= 1'b0;
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      state_q       <= ST_SEARCH;
      good_q        <= 3'd0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      hsync_q       <= hsync_in;
      vsync_q       <= vsync_in;
      hblnk_q       <= hblnk_in;
      vblnk_q       <= vblnk_in;
      hsync_prev_q  <= hsync_q;
      vsync_prev_q  <= vsync_q;
      hcount_q      <= n_h;
      vcount_q      <= n_v;
      state_q       <= state_d;
      good_q        <= good_d;
      frame_start_q <= frame_start_d;
      timing_err_q  <= timing_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign locked      = (state_q == ST_LOCKED);
  assign frame_start = frame_start_q;
  assign timing_err  = timing_err_q;
  assign err_cnt     = err_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster: a generator drives the
// timing inputs and a behavioural model predicts every output each cycle.
module tb_vga_sync_decoder;

  localparam int HT   = 20;
  localparam int VT   = 10;
  localparam int HS   = 16;
  localparam int VS   = 8;
  localparam int HB   = 14;
  localparam int VB   = 7;
  localparam int LOCK = 4;
  localparam int HSW  = 2;
  localparam int VSW  = 1;

  localparam int PH_SEARCH = 0;
  localparam int PH_HTRACK = 1;
  localparam int PH_VWAIT  = 2;
  localparam int PH_VTRACK = 3;
  localparam int PH_LOCKED = 4;

  logic        clk;
  logic        rst;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [10:0] hcount, vcount;
  logic        locked, frame_start, timing_err;
  logic [7:0]  err_cnt;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  vga_sync_decoder #(
    .HOR_TOTAL(HT), .VER_TOTAL(VT), .HSYNC_START(HS), .VSYNC_START(VS),
    .HBLANK_START(HB), .VBLANK_START(VB), .LOCK_LINES(LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .hcount(hcount), .vcount(vcount), .locked(locked), .frame_start(frame_start),
    .timing_err(timing_err), .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_h, m_v, m_cnt, m_phase, m_good, m_terr_total;
  bit m_fs, m_te;
  bit m_hs_q, m_hs_p, m_vs_q, m_vs_p, m_hb_q, m_vb_q;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_cnt = 0; m_phase = PH_SEARCH; m_good = 0;
    m_fs = 0; m_te = 0;
    m_hs_q = 0; m_hs_p = 0; m_vs_q = 0; m_vs_p = 0; m_hb_q = 0; m_vb_q = 0;
  endtask

  task automatic model_step();
    bit he, ve, wrap, h_bad, v_bad, fs, te;
    int fh, fv, nh, nv;
    he    = m_hs_q && !m_hs_p;
    ve    = m_vs_q && !m_vs_p;
    fh    = (m_h + 1) % HT;
    wrap  = (m_h == HT - 1) && !he;
    fv    = wrap ? (m_v + 1) % VT : m_v;
    nh    = he ? HS : fh;
    nv    = ve ? VS : fv;
    h_bad = he && (fh != HS);
    v_bad = ve && (fv != VS);
    fs    = (m_phase == PH_LOCKED) && nh == 0 && nv == 0;
    te    = 0;
    if (m_phase == PH_SEARCH) begin
      if (he) begin m_phase = PH_HTRACK; m_good = 0; end
    end else if (m_phase == PH_HTRACK) begin
      if (h_bad) m_good = 0;
      else if (he) begin
        m_good++;
        if (m_good == LOCK) m_phase = PH_VWAIT;
      end
    end else if (m_phase == PH_VWAIT || m_phase == PH_VTRACK) begin
      if (h_bad) begin m_phase = PH_HTRACK; m_good = 0; end
      else if (ve) begin
        if (m_phase == PH_VWAIT) m_phase = PH_VTRACK;
        else m_phase = v_bad ? PH_VWAIT : PH_LOCKED;
      end
    end else begin
      if (h_bad || v_bad || (m_hb_q != (nh >= HB)) || (m_vb_q != (nv >= VB))) begin
        te = 1;
        if (m_cnt < 255) m_cnt++;
        m_terr_total++;
        m_phase = PH_HTRACK;
        m_good = 0;
      end
    end
    m_h = nh; m_v = nv; m_fs = fs; m_te = te;
    m_hs_p = m_hs_q; m_vs_p = m_vs_q;
    m_hs_q = hsync_in; m_vs_q = vsync_in; m_hb_q = hblnk_in; m_vb_q = vblnk_in;
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (rst) model_reset();
    check("hcount", hcount, m_h);
    check("vcount", vcount, m_v);
    check("locked", locked, int'(m_phase == PH_LOCKED));
    check("frame_start", frame_start, m_fs);
    check("timing_err", timing_err, m_te);
    check("err_cnt", err_cnt, m_cnt);
    if (!rst) model_step();
  end

  // ---------------- generator / driver ----------------
  int g_h = 0;
  int g_v = 0;
  logic [10:0] exp_q[$];
  int          expv_q[$];

  // vs_mode: 0 natural, 1 force high, 2 force low
  task automatic gen_tick(input bit late, input bit [3:0] flip, input int vs_mode);
    bit hs, vs, hb, vb;
    int hs0;
    hs0 = late ? HS + 1 : HS;
    hs  = (g_h >= hs0) && (g_h < hs0 + HSW);
    vs  = (vs_mode == 1) ? 1'b1 : (vs_mode == 2) ? 1'b0 : ((g_v >= VS) && (g_v < VS + VSW));
    hb  = g_h >= HB;
    vb  = g_v >= VB;
    @(posedge clk);
    #1;
    hsync_in = hs ^ flip[0];
    vsync_in = vs ^ flip[1];
    hblnk_in = hb ^ flip[2];
    vblnk_in = vb ^ flip[3];
    exp_q.push_back(11'(g_h));
    expv_q.push_back(g_v);
    if (exp_q.size() > 3) begin
      void'(exp_q.pop_front());
      void'(expv_q.pop_front());
    end
    if (g_h == HT - 1) begin
      g_h = 0;
      g_v = (g_v + 1) % VT;
    end else begin
      g_h++;
    end
  endtask

  task automatic clean();
    gen_tick(1'b0, 4'b0000, 0);
  endtask

  task automatic wait_lock(input string name, input int budget);
    int n;
    n = 0;
    while (!locked && n < budget) begin
      clean();
      n++;
    end
    check(name, locked, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses, base, guard;
    bit late_line;
    bit [3:0] fl;
    rst = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    repeat (3) clean();
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_locked", locked, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // Clean stream: lock, then track one whole frame against delayed generator counts.
    wait_lock("initial_lock", 1000);
    pulses = 0;
    for (int i = 0; i < HT * VT; i++) begin
      clean();
      pulses += int'(frame_start);
      check("track_h", hcount, exp_q[0]);
      check("track_v", vcount, expv_q[0]);
    end
    check("frame_start_per_frame", pulses, 1);

    // One line with hsync one pixel late.
    while (g_h != 0) clean();
    pulses = 0;
    for (int i = 0; i < HT + 4; i++) begin
      gen_tick(i < HT, 4'b0000, 0);
      pulses += int'(timing_err);
    end
    check("late_hsync_pulses", pulses, 1);
    check("late_hsync_err_cnt", err_cnt, 1);
    check("late_hsync_unlocked", locked, 0);
    wait_lock("relock_after_late", 1000);

    // hblnk dropped for one pixel inside the blanking region.
    while (g_h != 0) clean();
    pulses = 0;
    for (int i = 0; i < HT + 4; i++) begin
      gen_tick(1'b0, (g_h == HB + 2) ? 4'b0100 : 4'b0000, 0);
      pulses += int'(timing_err);
    end
    check("hblnk_drop_pulses", pulses, 1);
    check("hblnk_drop_err_cnt", err_cnt, 2);
    check("hblnk_drop_unlocked", locked, 0);
    wait_lock("relock_after_hblnk", 1000);

    // Vsync edge arriving exactly on the line wrap out of the last line.
    while (!(g_h == 0 && g_v == 0)) clean();
    gen_tick(1'b0, 4'b0000, 1);
    clean();
    clean();
    check("vs_on_wrap_h", hcount, 0);
    check("vs_on_wrap_v", vcount, VS);

    // Randomised disturbances, including occasional resets.
    late_line = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      fl = 4'b0000;
      if ($urandom_range(0, 99) == 0) fl[$urandom_range(0, 3)] = 1'b1;
      if (g_h == 0) late_line = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        clean();
        rst = 1'b0;
      end
      gen_tick(late_line, fl, 0);
    end

    // Repeated lock/error cycles until the error counter must have saturated.
    base  = m_terr_total;
    guard = 0;
    while (m_terr_total - base < 300 && guard < 60000) begin
      if (m_phase == PH_LOCKED) begin
        gen_tick(1'b0, 4'b0100, 0);
        guard++;
      end else if (m_phase == PH_VWAIT) begin
        gen_tick(1'b0, 4'b0000, 2);
        gen_tick(1'b0, 4'b0000, 1);
        gen_tick(1'b0, 4'b0000, 2);
        gen_tick(1'b0, 4'b0000, 1);
        gen_tick(1'b0, 4'b0000, 2);
        guard += 5;
      end else begin
        clean();
        guard++;
      end
    end
    repeat (4) clean();
    check("err_cnt_saturated", err_cnt, 255);

    // Reset mid-line: outputs clear immediately, then reacquire from scratch.
    while (g_h != 7) clean();
    rst = 1'b1;
    #1;
    check("midline_rst_hcount", hcount, 0);
    check("midline_rst_vcount", vcount, 0);
    check("midline_rst_locked", locked, 0);
    check("midline_rst_fs", frame_start, 0);
    check("midline_rst_terr", timing_err, 0);
    check("midline_rst_err_cnt", err_cnt, 0);
    check("midline_rst_state", state_dbg, 0);
    clean();
    clean();
    rst = 1'b0;
    wait_lock("relock_after_rst", 1000);
    check("err_cnt_after_relock", err_cnt, 0);
    repeat (4) clean();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter HOR_TOTAL, default 1344: pixels per line incl. blanking.
REQ-002 Parameter VER_TOTAL, default 806: lines per frame incl. blanking.
REQ-003 Parameter HSYNC_START, default 1048: hcount of first hsync-high pixel.
REQ-004 Parameter VSYNC_START, default 771: vcount of first vsync-high line.
REQ-005 Parameter HBLANK_START, default 1024; VBLANK_START, default 768: first blanked pixel/line.
REQ-006 Parameter LOCK_LINES, default 4: consecutive matching hsync edges needed for line lock.
REQ-007 clk  in  1  pixel clock (65 MHz); single clock domain.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  incoming timing, active-high, synchronous to clk.
REQ-010 hcount  out  11  recovered horizontal position.
REQ-011 vcount  out  11  recovered vertical position.
REQ-012 locked  out  1  high only in state LOCKED.
REQ-013 frame_start  out  1  one-cycle pulse when hcount/vcount become 0/0.
REQ-014 timing_err  out  1  one-cycle pulse on a check failure while LOCKED.
REQ-015 err_cnt  out  8  saturating count of timing_err pulses.

Function
REQ-016 Stage 1 SHALL register all four inputs (*_q), plus previous hsync_q/vsync_q for edge detection; total input-to-hcount/vcount latency 2 cycles.
REQ-017 Next values n_h/n_v each cycle: n_h = HSYNC_START on hsync_q rising edge, else 0 if hcount==HOR_TOTAL-1, else hcount+1.
REQ-018 n_v = VSYNC_START on vsync_q rising edge (wins over line wrap), else on horizontal wrap (hcount==HOR_TOTAL-1, no hsync edge) vcount+1 mod VER_TOTAL, else unchanged.
REQ-019 hcount/vcount SHALL load n_h/n_v every cycle in all states; frame_start SHALL be registered high when n_h==0 and n_v==0 and state is LOCKED.
REQ-020 hsync edge match: free-running value (ignoring the edge) equals HSYNC_START; vsync edge match: free-running n_v equals VSYNC_START.
REQ-021 States SEARCH, H_TRACK, V_WAIT, V_TRACK, LOCKED; 3-bit good_lines counter.
REQ-022 SEARCH: first hsync edge -> H_TRACK, good_lines=0 (seed edge never counts as match).
REQ-023 H_TRACK: matching hsync edge increments good_lines; mismatch clears it; good_lines reaching LOCK_LINES -> V_WAIT.
REQ-024 V_WAIT: first vsync edge seeds vcount -> V_TRACK; V_TRACK: matching vsync edge -> LOCKED, mismatching -> V_WAIT.
REQ-025 V_WAIT/V_TRACK: mismatching hsync edge -> H_TRACK, good_lines=0.
REQ-026 LOCKED checks every cycle: hsync/vsync edge match, hblnk_q == (n_h>=HBLANK_START), vblnk_q == (n_v>=VBLANK_START).
REQ-027 Any LOCKED check failure -> timing_err=1 next cycle, err_cnt+1 saturating at 255, state H_TRACK, good_lines=0; multiple simultaneous failures count once.
REQ-028 timing_err and err_cnt SHALL never change outside LOCKED.

Reset
REQ-029 rst high SHALL immediately force state SEARCH, good_lines=0, all stage registers and all outputs 0.
REQ-030 Reset mid-frame SHALL discard lock; reacquisition follows REQ-022..024 from scratch.
REQ-031 err_cnt SHALL clear only on rst.

Verification
REQ-032 Clean 1024x768 stream from reset -> locked rises at second vsync edge after LOCK_LINES+1 lines; afterwards hcount/vcount equal generator counts delayed 2 cycles; frame_start once per 1344*806 cycles.
REQ-033 While LOCKED, hsync edge shifted 1 pixel late -> timing_err pulse, err_cnt=1, locked=0, relock after 4 good lines + 2 vsync edges.
REQ-034 While LOCKED, hblnk_in forced low at hcount 1030 -> single timing_err, err_cnt increments by 1.
REQ-035 Vsync edge coinciding with line wrap at vcount 805 -> vcount loads 771, not 0.
REQ-036 300 injected errors -> err_cnt saturates at 255; rst asserted mid-line -> all outputs 0 in same cycle, state SEARCH.
